// File: rtl/turfio_rst_pkg.sv
// rtl/turfio_rst_pkg.sv - shared state type, counter width and sizing helpers for the TURFIO MMCM reset sequencer
package turfio_rst_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_READY     = 2'd3
  } rst_state_t;

  localparam int CNT_W = 8;

  // Timer only ever needs to hold (largest window - 1).
  function automatic int timer_width(input int rst_cycles, input int lock_timeout,
                                     input int stable_cycles);
    int m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/turfio_mmcm_rst_fsm.sv
// rtl/turfio_mmcm_rst_fsm.sv - per-MMCM reset/lock sequencer with LOCKED synchronizer and status counters
module turfio_mmcm_rst_fsm
  import turfio_rst_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked_raw,
  input  logic             rst_req,
  input  logic             cnt_clr,
  output logic             mmcm_rst,
  output logic             ready,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] lost_cnt
);

  localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);

  logic          locked_m, locked_s;
  rst_state_t    state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          timeout_evt, lost_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked_raw;
      locked_s <= locked_m;
    end
  end

  always_comb begin
    state_nx    = state;
    timer_nx    = timer + 1'b1;
    timeout_evt = 1'b0;
    lost_evt    = 1'b0;
    case (state)
      ST_RESET: begin
        if (timer == RST_LAST) begin
          state_nx = ST_WAIT_LOCK;
          timer_nx = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nx = ST_STABLE;
          timer_nx = '0;
        end else if (timer == TIMEOUT_LAST) begin
          state_nx    = ST_RESET;
          timer_nx    = '0;
          timeout_evt = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_nx = ST_WAIT_LOCK;
          timer_nx = '0;
        end else if (timer == STABLE_LAST) begin
          state_nx = ST_READY;
          timer_nx = '0;
        end
      end
      ST_READY: begin
        timer_nx = '0;
        if (!locked_s) begin
          state_nx = ST_RESET;
          lost_evt = 1'b1;
        end
      end
      default: begin
        state_nx = ST_RESET;
        timer_nx = '0;
      end
    endcase
    // A request overrides the transition but the event it coincides with is still counted.
    if (rst_req) begin
      state_nx = ST_RESET;
      timer_nx = '0;
    end
  end

  // Outputs are registered from the next state so the MMCM reset pin never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RESET;
      timer    <= '0;
      mmcm_rst <= 1'b1;
      ready    <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      mmcm_rst <= (state_nx == ST_RESET);
      ready    <= (state_nx == ST_READY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt <= '0;
      lost_cnt    <= '0;
    end else if (cnt_clr) begin
      timeout_cnt <= '0;
      lost_cnt    <= '0;
    end else begin
      if (timeout_evt) timeout_cnt <= sat_inc(timeout_cnt);
      if (lost_evt)    lost_cnt    <= sat_inc(lost_cnt);
    end
  end

endmodule

// File: rtl/turfio_mmcm_rst_ctrl.sv
// rtl/turfio_mmcm_rst_ctrl.sv - dual-MMCM reset sequencer plus 1-in-8 sysclk phase marker
module turfio_mmcm_rst_ctrl
  import turfio_rst_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 256
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic [1:0]  mmcm_locked_i,
  input  logic [1:0]  rst_req_i,
  input  logic        cnt_clr_i,
  input  logic        phase_sync_i,
  output logic [1:0]  mmcm_rst_o,
  output logic [1:0]  ready_o,
  output logic [15:0] timeout_cnt_o,
  output logic [15:0] lost_cnt_o,
  output logic        sysclk_phase_o
);

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    turfio_mmcm_rst_fsm #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_fsm (
      .clk        (sysclk_i),
      .rst        (rst_i),
      .locked_raw (mmcm_locked_i[ch]),
      .rst_req    (rst_req_i[ch]),
      .cnt_clr    (cnt_clr_i),
      .mmcm_rst   (mmcm_rst_o[ch]),
      .ready      (ready_o[ch]),
      .timeout_cnt(timeout_cnt_o[ch*CNT_W +: CNT_W]),
      .lost_cnt   (lost_cnt_o[ch*CNT_W +: CNT_W])
    );
  end

  logic [2:0] phase_cnt;

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_cnt      <= 3'd0;
      sysclk_phase_o <= 1'b0;
    end else begin
      phase_cnt      <= phase_sync_i ? 3'd0 : phase_cnt + 3'd1;
      sysclk_phase_o <= (phase_cnt == 3'd7);
    end
  end

endmodule

// File: tb/tb_turfio_mmcm_rst_ctrl.sv
// tb/tb_turfio_mmcm_rst_ctrl.sv - directed and randomized bench for turfio_mmcm_rst_ctrl against a behavioural model
module tb_turfio_mmcm_rst_ctrl;

  localparam int RC = 4;
  localparam int TO = 100;
  localparam int SC = 8;
  localparam int M_RESET = 0, M_WAIT = 1, M_STABLE = 2, M_READY = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  locked = 2'b00;
  logic [1:0]  req = 2'b00;
  logic        clr = 1'b0;
  logic        psync = 1'b0;
  logic [1:0]  mmcm_rst, ready;
  logic [15:0] to_cnt, lost_cnt;
  logic        phase;

  int total = 0;
  int bad = 0;
  int edge_no = 0;

  // Behavioural model: countdown for the reset hold, wait/run lengths, saturating ints.
  int md_mode[2], md_left[2], md_wait[2], md_run[2], md_to[2], md_lost[2];
  bit md_m[2], md_s[2];
  int md_since;
  bit md_phase;

  always #5 clk = ~clk;

  turfio_mmcm_rst_ctrl #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC)
  ) dut (
    .sysclk_i      (clk),
    .rst_i         (rst),
    .mmcm_locked_i (locked),
    .rst_req_i     (req),
    .cnt_clr_i     (clr),
    .phase_sync_i  (psync),
    .mmcm_rst_o    (mmcm_rst),
    .ready_o       (ready),
    .timeout_cnt_o (to_cnt),
    .lost_cnt_o    (lost_cnt),
    .sysclk_phase_o(phase)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      md_mode[c] = M_RESET; md_left[c] = RC; md_wait[c] = 0; md_run[c] = 0;
      md_m[c] = 1'b0; md_s[c] = 1'b0; md_to[c] = 0; md_lost[c] = 0;
    end
    md_since = 0;
    md_phase = 1'b0;
  endfunction

  function automatic void model_step();
    for (int c = 0; c < 2; c++) begin
      bit ls, to_ev, lost_ev;
      ls = md_s[c];
      md_s[c] = md_m[c];
      md_m[c] = locked[c];
      to_ev = 1'b0;
      lost_ev = 1'b0;
      case (md_mode[c])
        M_RESET: begin
          md_left[c]--;
          if (md_left[c] == 0) begin md_mode[c] = M_WAIT; md_wait[c] = 0; end
        end
        M_WAIT: begin
          if (ls) begin
            md_mode[c] = M_STABLE; md_run[c] = 0;
          end else begin
            md_wait[c]++;
            if (md_wait[c] == TO) begin to_ev = 1'b1; md_mode[c] = M_RESET; md_left[c] = RC; end
          end
        end
        M_STABLE: begin
          if (!ls) begin
            md_mode[c] = M_WAIT; md_wait[c] = 0;
          end else begin
            md_run[c]++;
            if (md_run[c] == SC) md_mode[c] = M_READY;
          end
        end
        default: begin
          if (!ls) begin lost_ev = 1'b1; md_mode[c] = M_RESET; md_left[c] = RC; end
        end
      endcase
      if (req[c]) begin md_mode[c] = M_RESET; md_left[c] = RC; end
      if (clr) begin
        md_to[c] = 0; md_lost[c] = 0;
      end else begin
        if (to_ev && md_to[c] < 255) md_to[c]++;
        if (lost_ev && md_lost[c] < 255) md_lost[c]++;
      end
    end
    md_phase = ((md_since % 8) == 7);
    md_since = psync ? 0 : md_since + 1;
  endfunction

  task automatic compare_all();
    logic [1:0] e_rst, e_rdy;
    for (int c = 0; c < 2; c++) begin
      e_rst[c] = (md_mode[c] == M_RESET);
      e_rdy[c] = (md_mode[c] == M_READY);
    end
    check("mdl_mmcm_rst", 32'(mmcm_rst), 32'(e_rst));
    check("mdl_ready", 32'(ready), 32'(e_rdy));
    check("mdl_timeout_cnt", 32'(to_cnt), 32'({8'(md_to[1]), 8'(md_to[0])}));
    check("mdl_lost_cnt", 32'(lost_cnt), 32'({8'(md_lost[1]), 8'(md_lost[0])}));
    check("mdl_phase", 32'(phase), 32'(md_phase));
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_ready0(input int max_cycles);
    for (int i = 0; i < max_cycles && !ready[0]; i++) tick();
    check("wait_ready0", 32'(ready[0]), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2;
    check("reset_mmcm_rst", 32'(mmcm_rst), 3);
    check("reset_ready", 32'(ready), 0);
    check("reset_counters", 32'({to_cnt, lost_cnt}), 0);
    check("reset_phase", 32'(phase), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Power-up, channel 1 never locks.
    for (int e = 1; e <= 320; e++) begin
      tick();
      if (e == 10) locked[0] = 1'b1;
      if (e == 3) check("pu_rst0_e3", 32'(mmcm_rst[0]), 1);
      if (e == 4) check("pu_rst0_e4", 32'(mmcm_rst[0]), 0);
      if (e == 20) check("pu_ready0_e20", 32'(ready[0]), 0);
      if (e == 21) check("pu_ready0_e21", 32'(ready[0]), 1);
      if (e == 7 || e == 9) check("pu_phase_low", 32'(phase), 0);
      if (e == 8 || e == 16 || e == 24) check("pu_phase_pulse", 32'(phase), 1);
      if (e == 103) check("to_rst1_e103", 32'(mmcm_rst[1]), 0);
      if (e == 104 || e == 107) check("to_rst1_hold", 32'(mmcm_rst[1]), 1);
      if (e == 108) check("to_rst1_e108", 32'(mmcm_rst[1]), 0);
      if (e == 311) check("to_cnt1_e311", 32'(to_cnt[15:8]), 2);
      if (e == 312) begin
        check("to_cnt1_e312", 32'(to_cnt[15:8]), 3);
        check("to_cnt0_clean", 32'(to_cnt[7:0]), 0);
        check("ready0_unaffected", 32'(ready[0]), 1);
      end
    end

    // One-cycle LOCKED glitch in STABLE restarts the qualification window.
    req = 2'b01;
    tick();
    req = 2'b00;
    check("glitch_req_rst0", 32'(mmcm_rst[0]), 1);
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 8) locked[0] = 1'b0;
      if (k == 9) locked[0] = 1'b1;
      if (k == 19) check("glitch_ready0_k19", 32'(ready[0]), 0);
      if (k == 20) begin
        check("glitch_ready0_k20", 32'(ready[0]), 1);
        check("glitch_no_count", 32'({to_cnt[7:0], lost_cnt[7:0]}), 0);
      end
    end

    // Lock loss in READY.
    locked[0] = 1'b0;
    tick();
    tick();
    check("loss_ready_e2", 32'(ready[0]), 1);
    tick();
    check("loss_ready_e3", 32'(ready[0]), 0);
    check("loss_rst_e3", 32'(mmcm_rst[0]), 1);
    check("loss_cnt_e3", 32'(lost_cnt[7:0]), 1);

    for (int n = 0; n < 299; n++) begin
      locked[0] = 1'b1;
      wait_ready0(60);
      locked[0] = 1'b0;
      repeat (3) tick();
    end
    check("loss_saturate", 32'(lost_cnt[7:0]), 255);

    // Clear coincident with a lost increment.
    locked[0] = 1'b1;
    wait_ready0(60);
    locked[0] = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_wins_lost", 32'(lost_cnt[7:0]), 0);
    check("clr_timeout", 32'(to_cnt), 0);
    check("clr_edge_rst0", 32'(mmcm_rst[0]), 1);

    // Request together with lock drop in READY: one reset, one count.
    locked[0] = 1'b1;
    wait_ready0(60);
    locked[0] = 1'b0;
    tick();
    tick();
    req = 2'b01;
    tick();
    req = 2'b00;
    check("req_loss_rst0", 32'(mmcm_rst[0]), 1);
    check("req_loss_cnt", 32'(lost_cnt[7:0]), 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k <= 3) check("req_loss_hold", 32'(mmcm_rst[0]), 1);
      else check("req_loss_release", 32'(mmcm_rst[0]), 0);
    end

    // Phase realignment while the counter sits at 3.
    for (int i = 0; i < 8 && (md_since % 8) != 3; i++) tick();
    check("psync_at_3", 32'(md_since % 8), 3);
    psync = 1'b1;
    tick();
    psync = 1'b0;
    check("psync_edge_phase", 32'(phase), 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 7 || k == 9) check("psync_phase_low", 32'(phase), 0);
      if (k == 8 || k == 16) check("psync_phase_pulse", 32'(phase), 1);
    end

    // Asynchronous reset while channel 0 waits for lock.
    check("pre_rst_wait0", 32'(md_mode[0]), M_WAIT);
    #2 rst = 1'b1;
    #1;
    check("async_mmcm_rst", 32'(mmcm_rst), 3);
    check("async_ready", 32'(ready), 0);
    check("async_counters", 32'({to_cnt, lost_cnt}), 0);
    check("async_phase", 32'(phase), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 59) == 0) locked[c] = ~locked[c];
        req[c] = ($urandom_range(0, 149) == 0);
      end
      clr   = ($urandom_range(0, 299) == 0);
      psync = ($urandom_range(0, 63) == 0);
      tick();
    end
    req = 2'b00;
    clr = 1'b0;
    psync = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
